ysyx_24110006_axi_rom_slave: RTL and testbench
==============================================

# ysyx_24110006_axi_rom_slave

AXI4 read-only responder backing an on-chip word memory; it serves instruction-fetch and I-cache line-fill read bursts issued by the IFU/ICACHE AXI read master. It accepts one AR transaction at a time, waits a programmable access latency, then returns `arlen+1` beats with per-beat response codes and ID echo. A synchronous backdoor write port lets the loader or testbench fill the array.

## Interface
- `BASE_ADDR`, 32'h2000_0000: byte address of word 0.
- `DEPTH_WORDS`, 1024: array depth in 32-bit words; power of two.
- `LATENCY`, 2: idle cycles between AR acceptance and the first R beat; 0 to 15.
- `i_clock`  in  1  sole clock, rising edge.
- `i_reset`  in  1  reset, asynchronous, active-low (0 = in reset).
- `i_axi_araddr`  in  32  burst start byte address.
- `i_axi_arvalid`  in  1  AR valid.
- `o_axi_arready`  out  1  AR ready.
- `i_axi_arid`  in  4  transaction ID.
- `i_axi_arlen`  in  8  beats minus one.
- `i_axi_arsize`  in  3  must be 3'b010.
- `i_axi_arburst`  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `o_axi_rdata`  out  32  beat data.
- `o_axi_rvalid`  out  1  R valid.
- `i_axi_rready`  in  1  R ready.
- `o_axi_rresp`  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- `o_axi_rid`  out  4  echoed ID.
- `o_axi_rlast`  out  1  final beat.
- `i_wen`  in  1  backdoor write enable.
- `i_waddr`  in  log2(DEPTH_WORDS)  backdoor word index.
- `i_wdata`  in  32  backdoor write data.

## Operation
- States: IDLE, WAIT, BEAT.
- IDLE: `arready`=1. AR handshake (arvalid & arready at an edge) latches addr, id, len, burst, size; drops `arready`; goes to WAIT with counter=LATENCY, or directly to BEAT when LATENCY=0.
- WAIT: counter decrements each cycle; at 0, go to BEAT.
- BEAT: `rvalid`=1; rdata/rresp/rid/rlast held stable until `rready`. On handshake of a non-last beat, advance address and beat counter, load next beat, stay in BEAT. On handshake of the last beat, go to IDLE and set `arready`=1.
- Address step: FIXED unchanged; INCR +4; WRAP +4 within a (len+1)*4-byte aligned window, wrapping to the window base.
- Word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
- Per-beat response, in priority order:
  - arsize ≠ 3'b010, arburst = 11, or WRAP with len ∉ {1,3,7,15}: SLVERR, rdata 0, for every beat.
  - Beat address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4): DECERR, rdata 0.
  - Otherwise OKAY with array data.
- Error bursts still return exactly len+1 beats with rlast on the final beat.
- Backdoor write updates the array at the edge when `i_wen`=1. Beat data is sampled from the array at the edge that presents the beat, so a write at that same edge is not visible in that beat.

## Timing
- Reset (i_reset=0, asynchronous): state IDLE, `arready`=0, `rvalid`=0, `rlast`=0, `rresp`=00, `rid`=0, `rdata`=0. `arready` rises at the first clock edge after reset release. Array contents are not reset.
- Reset mid-burst aborts immediately. No further beats of that burst are issued after release.
- AR accepted at edge T: first `rvalid` is high in the cycle after edge T+LATENCY. With LATENCY=0 it is high in the cycle after T.
- With `rready` held high, beats stream one per cycle with no bubbles.
- `arready` is 0 from the AR handshake through the last R handshake, and 1 in the cycle after the last handshake. Minimum gap between bursts is therefore one cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `ysyx_24110006_axi_pkg` holds:
  - burst encodings (FIXED/INCR/WRAP);
  - resp codes (OKAY/SLVERR/DECERR);
  - size constant SIZE_4B=3'b010;
  - the state enum.
- One sub-module, `ysyx_24110006_axi_burst_addr`: combinational next-address from current address, len and burst type, including the WRAP mask.

## Test plan
- LATENCY=2, array[0]=0x0000_0013, AR araddr=0x2000_0000 len=0 INCR id=5 -> one beat 3 cycles after the AR edge: rdata 0x13, rresp 00, rid 5, rlast 1; `arready` is 1 the next cycle.
- Words 4..7 = 0xA..0xD, AR 0x2000_0018 len=3 WRAP -> data C, D, A, B; rlast only on the 4th beat.
- INCR len=3 with `rready` toggling 1,0,0,1,… -> rdata, rid and rlast stable while stalled; beat count 4; no beat lost or duplicated.
- AR 0x2000_0FFC len=1 INCR with DEPTH_WORDS=1024 -> beat0 OKAY, beat1 DECERR with rdata 0.
- arsize=3'b001, len=2 -> 3 SLVERR beats, rlast on the third; arburst=11 behaves the same.
- Assert reset during the 2nd beat of a len=7 burst -> `rvalid` and `arready` 0 immediately; after release, `arready`=1 at the next edge and a new AR completes normally.

Source files
------------

// File: rtl/ysyx_24110006_axi_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_axi_pkg
// Shared AXI encodings and the ROM responder state enum.
//   - burst encodings (FIXED / INCR / WRAP)
//   - response codes (OKAY / SLVERR / DECERR)
//   - the only supported transfer size (4 bytes)
//   - state_t for the responder FSM
// ---------------------------------------------------------------------------
package ysyx_24110006_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BEAT = 2'd2
    } state_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/ysyx_24110006_axi_burst_addr.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_axi_burst_addr
// Combinational next-beat address for 4-byte AXI bursts.
//   addr      in  32  address of the current beat
//   len       in  8   burst length minus one
//   burst     in  2   burst type
//   next_addr out 32  address of the following beat
// ---------------------------------------------------------------------------
module ysyx_24110006_axi_burst_addr
    import ysyx_24110006_axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;

    always_comb begin
        incr_addr = addr + 32'd4;
        // Window size is (len+1)*4 bytes; for legal wrap lengths the
        // byte mask (len+1)*4-1 equals {len, 2'b11}.
        wrap_mask = {22'd0, len, 2'b11};
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/ysyx_24110006_axi_rom_slave.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_axi_rom_slave
// AXI4 read-only responder over an on-chip word array. One AR at a time,
// programmable access latency, then arlen+1 R beats with per-beat response.
// Backdoor write port fills the array.
//
// Handshake rule: a transfer on AR or R happens at a rising edge where both
// valid and ready are high; the responder holds rvalid and all R payload
// stable until that edge, and never lowers rvalid without a handshake.
//
// Ports:
//   i_clock, i_reset            clock, async active-low reset
//   i_axi_ar*/o_axi_arready     read address channel
//   o_axi_r*/i_axi_rready       read data channel
//   i_wen/i_waddr/i_wdata       backdoor word write
//   o_dbg_state                 current FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module ysyx_24110006_axi_rom_slave
    import ysyx_24110006_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter int          AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic [31:0]   i_axi_araddr,
    input  logic          i_axi_arvalid,
    output logic          o_axi_arready,
    input  logic [3:0]    i_axi_arid,
    input  logic [7:0]    i_axi_arlen,
    input  logic [2:0]    i_axi_arsize,
    input  logic [1:0]    i_axi_arburst,
    output logic [31:0]   o_axi_rdata,
    output logic          o_axi_rvalid,
    input  logic          i_axi_rready,
    output logic [1:0]    o_axi_rresp,
    output logic [3:0]    o_axi_rid,
    output logic          o_axi_rlast,
    input  logic          i_wen,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    output logic [1:0]    o_dbg_state
);

    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS) * 32'd4;
    // Counter runs LATENCY-1 .. 0 so the beat is presented at edge T+LATENCY.
    localparam logic [3:0]  WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state_q;
    logic [3:0]  wait_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  left_q;
    logic [1:0]  burst_q;
    logic        err_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [3:0]  rid_q;
    logic        rlast_q;

    logic        ar_err;
    logic [31:0] next_addr;
    logic [31:0] load_addr;
    logic        load_err;
    logic [31:0] load_off;
    logic [AW-1:0] load_idx;
    logic [31:0] load_data;
    logic [1:0]  load_resp;

    ysyx_24110006_axi_burst_addr u_burst_addr (
        .addr      (addr_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Whole-burst protocol errors, judged once at AR time.
    always_comb begin
        ar_err = (i_axi_arsize != SIZE_4B)
              || (i_axi_arburst == BURST_RSVD)
              || ((i_axi_arburst == BURST_WRAP) && !wrap_len_ok(i_axi_arlen));
    end

    // Address and payload of the beat that would be presented at this edge:
    // the AR address when leaving IDLE (zero latency), the latched start
    // address when leaving WAIT, the stepped address while in BEAT.
    always_comb begin
        load_addr = addr_q;
        load_err  = err_q;
        if (state_q == ST_IDLE) begin
            load_addr = i_axi_araddr;
            load_err  = ar_err;
        end else if (state_q == ST_BEAT) begin
            load_addr = next_addr;
        end
        // Unsigned offset: addresses below BASE_ADDR wrap to huge values and
        // fall out of range in the same compare.
        load_off = load_addr - BASE_ADDR;
        load_idx = load_off[AW+1:2];
        if (load_err) begin
            load_resp = RESP_SLVERR;
            load_data = 32'd0;
        end else if (load_off >= SPAN) begin
            load_resp = RESP_DECERR;
            load_data = 32'd0;
        end else begin
            load_resp = RESP_OKAY;
            load_data = mem[load_idx];
        end
    end

    // Array is not reset; beat sampling reads the pre-write value.
    always_ff @(posedge i_clock) begin
        if (i_wen) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            wait_q    <= 4'd0;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            left_q    <= 8'd0;
            burst_q   <= BURST_FIXED;
            err_q     <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= 4'd0;
            rlast_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arready_q && i_axi_arvalid) begin
                        arready_q <= 1'b0;
                        addr_q    <= i_axi_araddr;
                        len_q     <= i_axi_arlen;
                        left_q    <= i_axi_arlen;
                        burst_q   <= i_axi_arburst;
                        err_q     <= ar_err;
                        rid_q     <= i_axi_arid;
                        if (LATENCY == 0) begin
                            state_q  <= ST_BEAT;
                            rvalid_q <= 1'b1;
                            rdata_q  <= load_data;
                            rresp_q  <= load_resp;
                            rlast_q  <= (i_axi_arlen == 8'd0);
                        end else begin
                            state_q  <= ST_WAIT;
                            wait_q   <= WAIT_INIT;
                        end
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wait_q == 4'd0) begin
                        state_q  <= ST_BEAT;
                        rvalid_q <= 1'b1;
                        rdata_q  <= load_data;
                        rresp_q  <= load_resp;
                        rlast_q  <= (left_q == 8'd0);
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                ST_BEAT: begin
                    if (i_axi_rready) begin
                        if (left_q == 8'd0) begin
                            state_q   <= ST_IDLE;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                        end else begin
                            addr_q  <= load_addr;
                            left_q  <= left_q - 8'd1;
                            rdata_q <= load_data;
                            rresp_q <= load_resp;
                            rlast_q <= (left_q == 8'd1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_axi_arready = arready_q;
    assign o_axi_rvalid  = rvalid_q;
    assign o_axi_rdata   = rdata_q;
    assign o_axi_rresp   = rresp_q;
    assign o_axi_rid     = rid_q;
    assign o_axi_rlast   = rlast_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_ysyx_24110006_axi_rom_slave.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24110006_axi_rom_slave
// Directed bench for the AXI ROM responder (LATENCY=2, DEPTH_WORDS=1024).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ysyx_24110006_axi_rom_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'b010;
    logic [1:0]  arburst = 2'b01;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        wen = 1'b0;
    logic [9:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    ysyx_24110006_axi_rom_slave #(
        .BASE_ADDR   (32'h2000_0000),
        .DEPTH_WORDS (1024),
        .LATENCY     (2)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_axi_araddr  (araddr),
        .i_axi_arvalid (arvalid),
        .o_axi_arready (arready),
        .i_axi_arid    (arid),
        .i_axi_arlen   (arlen),
        .i_axi_arsize  (arsize),
        .i_axi_arburst (arburst),
        .o_axi_rdata   (rdata),
        .o_axi_rvalid  (rvalid),
        .i_axi_rready  (rready),
        .o_axi_rresp   (rresp),
        .o_axi_rid     (rid),
        .o_axi_rlast   (rlast),
        .i_wen         (wen),
        .i_waddr       (waddr),
        .i_wdata       (wdata),
        .o_dbg_state   (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called at a falling edge; returns at the falling edge after acceptance
    task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] id);
        int n;
        araddr = a; arlen = l; arsize = s; arburst = b; arid = id; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ar_ready_seen", 32'(arready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        chk("ar_ready_drop", 32'(arready), 32'd0);
    endtask

    // rready held high; called and returns at a falling edge
    task automatic get_beat(input string tag, input logic [31:0] ed, input logic [1:0] er,
                            input logic [3:0] eid, input logic el, output int waits);
        waits = 0;
        while (!rvalid && waits < 30) begin
            @(negedge clk);
            waits++;
        end
        chk({tag, ".valid"}, 32'(rvalid), 32'd1);
        chk({tag, ".data"},  rdata, ed);
        chk({tag, ".resp"},  32'(rresp), 32'(er));
        chk({tag, ".id"},    32'(rid), 32'(eid));
        chk({tag, ".last"},  32'(rlast), 32'(el));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bd_write(input logic [9:0] idx, input logic [31:0] d);
        wen = 1'b1; waddr = idx; wdata = d;
        @(posedge clk);
        @(negedge clk);
        wen = 1'b0;
    endtask

    initial begin
        int w;
        int k;
        int vc;
        logic hs;
        logic rr;
        logic pat [4];
        logic [31:0] exp3 [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        chk("rst.arready", 32'(arready), 32'd0);
        chk("rst.rvalid",  32'(rvalid),  32'd0);
        chk("rst.rlast",   32'(rlast),   32'd0);
        chk("rst.rresp",   32'(rresp),   32'd0);
        chk("rst.rid",     32'(rid),     32'd0);
        chk("rst.rdata",   rdata,        32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel.arready_before_edge", 32'(arready), 32'd0);
        @(negedge clk);
        chk("rel.arready_after_edge", 32'(arready), 32'd1);

        // ---------------- backdoor fill ----------------
        bd_write(10'd0, 32'h0000_0013);
        bd_write(10'd4, 32'h0000_000A);
        bd_write(10'd5, 32'h0000_000B);
        bd_write(10'd6, 32'h0000_000C);
        bd_write(10'd7, 32'h0000_000D);
        for (int i = 0; i < 4; i++) begin
            exp3[i] = 32'h100 + 32'(i);
            bd_write(10'(8 + i), exp3[i]);
        end
        bd_write(10'd1023, 32'hCAFE_F00D);

        // ---------------- single beat, latency ----------------
        send_ar(32'h2000_0000, 8'd0, 3'b010, 2'b01, 4'd5);
        chk("t1.lat_c1", 32'(rvalid), 32'd0);
        @(negedge clk);
        chk("t1.lat_c2", 32'(rvalid), 32'd0);
        @(negedge clk);
        chk("t1.lat_c3", 32'(rvalid), 32'd1);
        get_beat("t1.b0", 32'h13, 2'b00, 4'd5, 1'b1, w);
        chk("t1.wait", 32'(w), 32'd0);
        chk("t1.arready_after", 32'(arready), 32'd1);
        chk("t1.rvalid_after",  32'(rvalid),  32'd0);

        // ---------------- WRAP len=3 from word 6 ----------------
        send_ar(32'h2000_0018, 8'd3, 3'b010, 2'b10, 4'd3);
        get_beat("t2.b0", 32'hC, 2'b00, 4'd3, 1'b0, w);
        get_beat("t2.b1", 32'hD, 2'b00, 4'd3, 1'b0, w);
        chk("t2.stream1", 32'(w), 32'd0);
        get_beat("t2.b2", 32'hA, 2'b00, 4'd3, 1'b0, w);
        chk("t2.stream2", 32'(w), 32'd0);
        get_beat("t2.b3", 32'hB, 2'b00, 4'd3, 1'b1, w);
        chk("t2.stream3", 32'(w), 32'd0);
        chk("t2.arready_after", 32'(arready), 32'd1);
        chk("t2.rvalid_after",  32'(rvalid),  32'd0);

        // ---------------- INCR len=3 with rready stalls ----------------
        send_ar(32'h2000_0020, 8'd3, 3'b010, 2'b01, 4'd9);
        k = 0;
        vc = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            if (rvalid) begin
                chk("t3.data", rdata, exp3[k]);
                chk("t3.id",   32'(rid), 32'd9);
                chk("t3.last", 32'(rlast), (k == 3) ? 32'd1 : 32'd0);
                rr = pat[vc % 4];
                vc++;
            end else begin
                rr = 1'b1;
            end
            rready = rr;
            hs = rvalid && rr;
            @(posedge clk);
            if (hs) k++;
            @(negedge clk);
        end
        rready = 1'b1;
        chk("t3.beats", 32'(k), 32'd4);
        chk("t3.valid_cycles", 32'(vc), 32'd8);
        chk("t3.rvalid_after", 32'(rvalid), 32'd0);
        chk("t3.arready_after", 32'(arready), 32'd1);

        // ---------------- top-of-array crossing ----------------
        send_ar(32'h2000_0FFC, 8'd1, 3'b010, 2'b01, 4'd1);
        get_beat("t4.b0", 32'hCAFE_F00D, 2'b00, 4'd1, 1'b0, w);
        get_beat("t4.b1", 32'h0, 2'b11, 4'd1, 1'b1, w);

        // ---------------- bad size ----------------
        send_ar(32'h2000_0000, 8'd2, 3'b001, 2'b01, 4'd2);
        get_beat("t5.b0", 32'h0, 2'b10, 4'd2, 1'b0, w);
        get_beat("t5.b1", 32'h0, 2'b10, 4'd2, 1'b0, w);
        get_beat("t5.b2", 32'h0, 2'b10, 4'd2, 1'b1, w);

        // ---------------- reserved burst ----------------
        send_ar(32'h2000_0000, 8'd2, 3'b010, 2'b11, 4'd7);
        get_beat("t6.b0", 32'h0, 2'b10, 4'd7, 1'b0, w);
        get_beat("t6.b1", 32'h0, 2'b10, 4'd7, 1'b0, w);
        get_beat("t6.b2", 32'h0, 2'b10, 4'd7, 1'b1, w);

        // ---------------- FIXED len=1 ----------------
        send_ar(32'h2000_0010, 8'd1, 3'b010, 2'b00, 4'd8);
        get_beat("t7.b0", 32'hA, 2'b00, 4'd8, 1'b0, w);
        get_beat("t7.b1", 32'hA, 2'b00, 4'd8, 1'b1, w);

        // ---------------- reset mid-burst ----------------
        send_ar(32'h2000_0000, 8'd7, 3'b010, 2'b01, 4'd4);
        get_beat("t8.b0", 32'h13, 2'b00, 4'd4, 1'b0, w);
        chk("t8.b1_valid", 32'(rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t8.rst_rvalid",  32'(rvalid),  32'd0);
        chk("t8.rst_arready", 32'(arready), 32'd0);
        chk("t8.rst_rlast",   32'(rlast),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t8.rel_arready0", 32'(arready), 32'd0);
        @(negedge clk);
        chk("t8.rel_arready1", 32'(arready), 32'd1);
        chk("t8.rel_rvalid",   32'(rvalid),  32'd0);
        @(negedge clk);
        chk("t8.no_stale_beat", 32'(rvalid), 32'd0);
        send_ar(32'h2000_0000, 8'd0, 3'b010, 2'b01, 4'd6);
        get_beat("t8.new", 32'h13, 2'b00, 4'd6, 1'b1, w);
        chk("t8.new_wait", 32'(w), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
